// File: rtl/pc_unit_if.sv
// Fetch-PC bus between the control unit and the PC unit.
// The master drives the next-PC controls; the slave returns the PC state.
interface pc_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  stall;
    logic [1:0]            PCsrc;
    logic [DATA_WIDTH-1:0] ImmOp;
    logic [DATA_WIDTH-1:0] rs1;
    logic                  ras_push;
    logic                  ras_pop;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pcplus4;
    logic [CNT_WIDTH-1:0]  count;
    logic [DATA_WIDTH-1:0] ras_top;
    logic                  ras_empty;
    logic                  ras_full;

    modport master (
        output stall, PCsrc, ImmOp, rs1, ras_push, ras_pop,
        input  pc, pcplus4, count, ras_top, ras_empty, ras_full
    );

    modport slave (
        input  stall, PCsrc, ImmOp, rs1, ras_push, ras_pop,
        output pc, pcplus4, count, ras_top, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC generator: next-PC mux, fetch counter and return-address stack.
// The RAS is a circular buffer whose oldest entry is overwritten on overflow.
module pc_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    CNT_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    RAS_DEPTH    = 4
) (
    input logic        clk,
    input logic        rst,
    pc_unit_if.slave   bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(RAS_DEPTH);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]      tp_q, tp_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [DATA_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [DATA_WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [DATA_WIDTH-1:0] pcplus4;
    logic [DATA_WIDTH-1:0] jalr_sum;

    assign pcplus4  = pc_q + DATA_WIDTH'(4);
    assign jalr_sum = bus.rs1 + bus.ImmOp;

    // Next PC and fetch counter; everything holds while stalled.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (!bus.stall) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            unique case (bus.PCsrc)
                2'b00: pc_d = pcplus4;
                2'b01: pc_d = pc_q + bus.ImmOp;
                2'b10: pc_d = bus.ImmOp;
                2'b11: pc_d = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
                default: pc_d = pcplus4;
            endcase
        end
    end

    // RAS update: push+pop on a non-empty stack replaces the top entry,
    // pop on an empty stack is ignored.
    always_comb begin
        tp_d  = tp_q;
        occ_d = occ_q;
        ras_d = ras_q;
        if (!bus.stall) begin
            if (bus.ras_push && bus.ras_pop && occ_q != '0) begin
                ras_d[tp_q] = pcplus4;
            end else if (bus.ras_push) begin
                tp_d        = tp_q + PTR_W'(1);
                ras_d[tp_d] = pcplus4;
                if (occ_q != OCC_MAX) begin
                    occ_d = occ_q + OCC_W'(1);
                end
            end else if (bus.ras_pop && occ_q != '0) begin
                tp_d  = tp_q - PTR_W'(1);
                occ_d = occ_q - OCC_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_VECTOR;
            cnt_q <= '0;
            tp_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            tp_q  <= tp_d;
            occ_q <= occ_d;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pcplus4   = pcplus4;
    assign bus.count     = cnt_q;
    assign bus.ras_empty = (occ_q == '0);
    assign bus.ras_full  = (occ_q == OCC_MAX);
    assign bus.ras_top   = (occ_q != '0) ? ras_q[tp_q] : '0;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: next-PC modes, stall, counter, RAS, reset.
module tb_pc_unit;
    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   exp_cnt;

    pc_unit_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) bus ();

    pc_unit #(
        .DATA_WIDTH(32),
        .CNT_WIDTH(32),
        .RESET_VECTOR(32'h0),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // One clock edge; inputs stay as set, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst && !bus.stall) exp_cnt++;
        #1;
    endtask

    task automatic drive(input logic [1:0] src, input logic [31:0] imm,
                         input logic psh, input logic pp);
        bus.PCsrc    = src;
        bus.ImmOp    = imm;
        bus.ras_push = psh;
        bus.ras_pop  = pp;
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        exp_cnt  = 0;
        rst      = 1'b0;
        bus.stall = 1'b0;
        bus.rs1   = '0;
        drive(2'b00, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_cnt", bus.count, 32'h0);
        chk("rst_empty", {31'b0, bus.ras_empty}, 32'h1);
        chk("rst_full", {31'b0, bus.ras_full}, 32'h0);
        chk("rst_top", bus.ras_top, 32'h0);
        rst = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            step();
            chk("seq_pc", bus.pc, 32'(4 * i));
        end
        chk("seq_cnt", bus.count, 32'd3);
        chk("seq_pc4", bus.pcplus4, 32'h10);

        drive(2'b10, 32'h100, 1'b0, 1'b0);
        step();
        chk("jal_100", bus.pc, 32'h100);
        drive(2'b01, 32'hFFFF_FFF8, 1'b0, 1'b0);
        step();
        chk("br_neg", bus.pc, 32'hF8);
        drive(2'b10, 32'h2000, 1'b0, 1'b0);
        step();
        chk("jal_abs", bus.pc, 32'h2000);
        drive(2'b10, 32'hFFFF_FFFC, 1'b0, 1'b0);
        step();
        chk("pc4_wrap", bus.pcplus4, 32'h0);
        drive(2'b00, '0, 1'b0, 1'b0);
        step();
        chk("seq_wrap", bus.pc, 32'h0);
        bus.rs1 = 32'h1001;
        drive(2'b11, 32'h2, 1'b0, 1'b0);
        step();
        chk("jalr_lsb", bus.pc, 32'h1002);
        chk("cnt_9", bus.count, 32'd9);

        bus.stall = 1'b1;
        drive(2'b01, 32'h40, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stl_pc", bus.pc, 32'h1002);
            chk("stl_cnt", bus.count, 32'd9);
            chk("stl_empty", {31'b0, bus.ras_empty}, 32'h1);
            chk("stl_pc4", bus.pcplus4, 32'h1006);
        end
        bus.stall = 1'b0;
        drive(2'b01, 32'h40, 1'b0, 1'b0);
        step();
        chk("unstl_pc", bus.pc, 32'h1042);
        chk("unstl_cnt", bus.count, 32'(exp_cnt));

        drive(2'b10, 32'h10, 1'b0, 1'b0);
        step();
        for (int k = 2; k <= 6; k++) begin
            drive(2'b10, 32'(16 * k), 1'b1, 1'b0);
            step();
            chk("push_top", bus.ras_top, 32'(16 * (k - 1) + 4));
        end
        chk("ovf_full", {31'b0, bus.ras_full}, 32'h1);
        chk("ovf_top", bus.ras_top, 32'h54);

        drive(2'b00, '0, 1'b0, 1'b1);
        step();
        chk("pop1_top", bus.ras_top, 32'h44);
        chk("pop1_full", {31'b0, bus.ras_full}, 32'h0);
        step();
        chk("pop2_top", bus.ras_top, 32'h34);
        step();
        chk("pop3_top", bus.ras_top, 32'h24);
        chk("pop3_empty", {31'b0, bus.ras_empty}, 32'h0);

        drive(2'b10, 32'h80, 1'b0, 1'b0);
        step();
        drive(2'b00, '0, 1'b1, 1'b1);
        step();
        chk("repl_top", bus.ras_top, 32'h84);
        chk("repl_pc", bus.pc, 32'h84);
        drive(2'b00, '0, 1'b0, 1'b1);
        step();
        chk("occ1_top", bus.ras_top, 32'h0);
        chk("occ1_empty", {31'b0, bus.ras_empty}, 32'h1);
        step();
        chk("undf_top", bus.ras_top, 32'h0);
        chk("undf_empty", {31'b0, bus.ras_empty}, 32'h1);
        chk("undf_full", {31'b0, bus.ras_full}, 32'h0);

        drive(2'b00, '0, 1'b1, 1'b1);
        step();
        chk("pp_empty_top", bus.ras_top, 32'h90);
        chk("pp_empty_emp", {31'b0, bus.ras_empty}, 32'h0);
        chk("cnt_run", bus.count, 32'(exp_cnt));

        drive(2'b00, '0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_pc", bus.pc, 32'h0);
        chk("arst_empty", {31'b0, bus.ras_empty}, 32'h1);
        chk("arst_top", bus.ras_top, 32'h0);
        chk("arst_cnt", bus.count, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
